// File: rtl/ym_i2s_tx.sv
// ym_i2s_tx: re-serializes the parallel stereo sample stream as Philips I2S.
// Ports:
//   AMCLK_i          audio master clock (only clock)
//   reset_n          synchronous active-low reset
//   APDATA_LEFT_i    signed left sample, I2S_DATA_BITS wide
//   APDATA_RIGHT_i   signed right sample, I2S_DATA_BITS wide
//   APDATA_VALID_i   one-cycle strobe qualifying the sample pair
//   I2S_BCK_o        bit clock, BCK_DIV AMCLK cycles per period, 50% duty
//   I2S_WS_o         word select, 0 = left, 1 = right (leads slot MSB by one BCK)
//   I2S_DATA_o       serial data, MSB first, zero-padded to SLOT_BITS
//   FRAME_START_o    one-cycle pulse with the first left MSB
//   REPEAT_CNT_o     saturating count of frames sent without a fresh sample
//   DROP_CNT_o       saturating count of samples overwritten before sending
module ym_i2s_tx #(
  parameter int unsigned I2S_DATA_BITS = 16,
  parameter int unsigned SLOT_BITS     = 32,
  parameter int unsigned BCK_DIV       = 4
) (
  input  logic                     AMCLK_i,
  input  logic                     reset_n,
  input  logic [I2S_DATA_BITS-1:0] APDATA_LEFT_i,
  input  logic [I2S_DATA_BITS-1:0] APDATA_RIGHT_i,
  input  logic                     APDATA_VALID_i,
  output logic                     I2S_BCK_o,
  output logic                     I2S_WS_o,
  output logic                     I2S_DATA_o,
  output logic                     FRAME_START_o,
  output logic [7:0]               REPEAT_CNT_o,
  output logic [7:0]               DROP_CNT_o
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned BW         = $clog2(FRAME_BITS);
  localparam int unsigned DW         = $clog2(BCK_DIV);
  localparam int unsigned IW         = (I2S_DATA_BITS > 1) ? $clog2(I2S_DATA_BITS) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] WS_FIRST = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] WS_LAST  = BW'(FRAME_BITS - 2);
  localparam logic [BW-1:0] SLOT_IDX = BW'(SLOT_BITS);
  localparam logic [BW-1:0] DATA_LEN = BW'(I2S_DATA_BITS);
  localparam logic [BW-1:0] MSB_IDX  = BW'(I2S_DATA_BITS - 1);

  logic [DW-1:0]            div_ctr;
  logic [BW-1:0]            bit_ctr;
  logic [I2S_DATA_BITS-1:0] hold_l, hold_r;
  logic [I2S_DATA_BITS-1:0] out_l, out_r;
  logic                     pending;

  logic                     load_c;
  logic                     data_c;
  logic [BW-1:0]            slot_idx;
  logic [BW-1:0]            rev_idx;

  // Last AMCLK cycle of the frame: the frame being started next takes the hold register.
  assign load_c = (div_ctr == DIV_LAST) && (bit_ctr == BIT_LAST);

  // Serial bit for the current bit_ctr; positions past the sample width pad with zero.
  always_comb begin
    data_c   = 1'b0;
    slot_idx = bit_ctr;
    if (bit_ctr >= SLOT_IDX) begin
      slot_idx = bit_ctr - SLOT_IDX;
    end
    rev_idx = MSB_IDX - slot_idx;
    if (slot_idx < DATA_LEN) begin
      data_c = (bit_ctr < SLOT_IDX) ? out_l[rev_idx[IW-1:0]] : out_r[rev_idx[IW-1:0]];
    end
  end

  // Timing counters, registered I2S outputs, hold/out registers and status counters.
  always_ff @(posedge AMCLK_i) begin
    if (!reset_n) begin
      div_ctr       <= '0;
      bit_ctr       <= '0;
      hold_l        <= '0;
      hold_r        <= '0;
      out_l         <= '0;
      out_r         <= '0;
      pending       <= 1'b0;
      I2S_BCK_o     <= 1'b0;
      I2S_WS_o      <= 1'b0;
      I2S_DATA_o    <= 1'b0;
      FRAME_START_o <= 1'b0;
      REPEAT_CNT_o  <= '0;
      DROP_CNT_o    <= '0;
    end else begin
      if (div_ctr == DIV_LAST) begin
        div_ctr <= '0;
        bit_ctr <= (bit_ctr == BIT_LAST) ? '0 : bit_ctr + BW'(1);
      end else begin
        div_ctr <= div_ctr + DW'(1);
      end

      // Outputs trail the counters by one cycle, so WS/DATA move with the BCK fall.
      I2S_BCK_o     <= (div_ctr >= DIV_HALF);
      I2S_WS_o      <= (bit_ctr >= WS_FIRST) && (bit_ctr <= WS_LAST);
      I2S_DATA_o    <= data_c;
      FRAME_START_o <= (div_ctr == '0) && (bit_ctr == '0);

      if (load_c) begin
        out_l <= hold_l;
        out_r <= hold_r;
        if (!pending && (REPEAT_CNT_o != 8'hFF)) begin
          REPEAT_CNT_o <= REPEAT_CNT_o + 8'd1;
        end
      end

      // A strobe on the load cycle is kept for the next frame and is not a drop.
      if (APDATA_VALID_i) begin
        hold_l  <= APDATA_LEFT_i;
        hold_r  <= APDATA_RIGHT_i;
        pending <= 1'b1;
        if (pending && !load_c && (DROP_CNT_o != 8'hFF)) begin
          DROP_CNT_o <= DROP_CNT_o + 8'd1;
        end
      end else if (load_c) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ym_i2s_tx.sv
// tb_ym_i2s_tx: directed self-checking bench for ym_i2s_tx at default parameters.
// Frame = 64 BCK * 4 AMCLK = 256 cycles. cyc counts cycles since reset release;
// the outputs seen at cyc c reflect the counters of cycle c-1.
module tb_ym_i2s_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] left, right;
  logic        valid;
  logic        bck, ws, data, frame_start;
  logic [7:0]  rep_cnt, drop_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;

  ym_i2s_tx dut (
    .AMCLK_i        (clk),
    .reset_n        (reset_n),
    .APDATA_LEFT_i  (left),
    .APDATA_RIGHT_i (right),
    .APDATA_VALID_i (valid),
    .I2S_BCK_o      (bck),
    .I2S_WS_o       (ws),
    .I2S_DATA_o     (data),
    .FRAME_START_o  (frame_start),
    .REPEAT_CNT_o   (rep_cnt),
    .DROP_CNT_o     (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Two reset edges; afterwards the DUT is in cycle 0 with counters at zero.
  task automatic apply_reset();
    reset_n = 1'b0;
    valid   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  // Strobe one sample pair during cycle c.
  task automatic send(input int c, input logic [15:0] l, input logic [15:0] r);
    run_to(c);
    left  = l;
    right = r;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  function automatic logic exp_bit(input int k, input logic [15:0] l, input logic [15:0] r);
    logic [15:0] lv, rv;
    lv = l;
    rv = r;
    if (k < 16) return lv[15-k];
    if (k >= 32 && k < 48) return rv[47-k];
    return 1'b0;
  endfunction

  // Compare every output cycle up to the end of frame f against the timing model.
  task automatic scan_frame(input int f, input logic [15:0] l, input logic [15:0] r,
                            input string tag);
    int errs = 0;
    int p, dv, k;
    while (cyc < 256 * f + 256) begin
      tick();
      p  = cyc - 1;
      dv = p % 4;
      k  = (p / 4) % 64;
      if (bck !== (dv >= 2)) errs++;
      if (ws !== (k >= 31 && k <= 62)) errs++;
      if (data !== exp_bit(k, l, r)) errs++;
      if (frame_start !== ((p % 256) == 0)) errs++;
    end
    check(tag, 32'(errs), 32'd0);
  endtask

  // Collect the left and right words of frame f from the serial line.
  task automatic get_frame(input int f, output logic [15:0] l, output logic [15:0] r);
    l = '0;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      run_to(256 * f + 4 * k + 2);
      l[15-k] = data;
    end
    for (int k = 32; k < 48; k++) begin
      run_to(256 * f + 4 * k + 2);
      r[47-k] = data;
    end
  endtask

  initial begin
    logic [15:0] wl, wr;
    reset_n = 1'b0;
    valid   = 1'b0;
    left    = '0;
    right   = '0;

    // Basic frame: 0x8001 / 0x7FFE strobed in frame 0, sent in frame 1.
    apply_reset();
    check("rst_bck", 32'(bck), 32'd0);
    check("rst_ws", 32'(ws), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_counts", {16'd0, rep_cnt, drop_cnt}, 32'd0);
    send(10, 16'h8001, 16'h7FFE);
    scan_frame(0, 16'h0000, 16'h0000, "t1_frame0_zero");
    check("t1_rep_after_load", 32'(rep_cnt), 32'd0);
    scan_frame(1, 16'h8001, 16'h7FFE, "t1_frame1_serial");
    check("t1_drop", 32'(drop_cnt), 32'd0);
    check("t1_rep_second_load", 32'(rep_cnt), 32'd1);

    // No input for three frames: zeros, one repeat per load.
    apply_reset();
    scan_frame(0, 16'h0000, 16'h0000, "t2_frame0");
    check("t2_rep_1", 32'(rep_cnt), 32'd1);
    scan_frame(1, 16'h0000, 16'h0000, "t2_frame1");
    scan_frame(2, 16'h0000, 16'h0000, "t2_frame2");
    check("t2_rep_3", 32'(rep_cnt), 32'd3);
    check("t2_drop", 32'(drop_cnt), 32'd0);

    // Two strobes before the load: the newer wins, one drop.
    apply_reset();
    send(20, 16'h1111, 16'h1111);
    send(40, 16'h2222, 16'h2222);
    get_frame(1, wl, wr);
    check("t3_left", 32'(wl), 32'h2222);
    check("t3_right", 32'(wr), 32'h2222);
    check("t3_drop", 32'(drop_cnt), 32'd1);
    check("t3_rep", 32'(rep_cnt), 32'd0);

    // Strobe exactly on the load cycle: old sample sent now, new one next frame.
    apply_reset();
    send(100, 16'h1234, 16'hEDCB);
    send(255, 16'h5A5A, 16'hA5A5);
    get_frame(1, wl, wr);
    check("t4_f1_left", 32'(wl), 32'h1234);
    check("t4_f1_right", 32'(wr), 32'hEDCB);
    get_frame(2, wl, wr);
    check("t4_f2_left", 32'(wl), 32'h5A5A);
    check("t4_f2_right", 32'(wr), 32'hA5A5);
    check("t4_drop", 32'(drop_cnt), 32'd0);
    check("t4_rep", 32'(rep_cnt), 32'd0);

    // 300 strobes two cycles apart: drop counter saturates at 255.
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      send(2 + 2 * i, 16'(i), 16'(~i));
      if (i == 99) check("t5_drop_99", 32'(drop_cnt), 32'd99);
    end
    tick();
    check("t5_drop_sat", 32'(drop_cnt), 32'd255);
    check("t5_rep", 32'(rep_cnt), 32'd0);

    // One-cycle reset in the middle of the right slot.
    apply_reset();
    send(10, 16'hFFFF, 16'hFFFF);
    send(12, 16'hFFFF, 16'hFFFF);
    run_to(420);
    check("t6_pre_outs", {29'd0, bck, ws, data}, 32'h7);
    check("t6_pre_drop", 32'(drop_cnt), 32'd1);
    reset_n = 1'b0;
    tick();
    check("t6_rst_outs", {28'd0, bck, ws, data, frame_start}, 32'd0);
    check("t6_rst_counts", {16'd0, rep_cnt, drop_cnt}, 32'd0);
    reset_n = 1'b1;
    cyc     = 0;
    scan_frame(0, 16'h0000, 16'h0000, "t6_restart_frame0");
    check("t6_rep_first_load", 32'(rep_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
